// File: rtl/perceptron_update_if.sv
// Sample handshake bundle between the training sequencer and perceptron_update.
// The sequencer drives the sample; the update block answers with ready/done/mistake.
interface perceptron_update_if #(
   parameter int N = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [N-1:0]        x;
   logic                target;
   logic signed [31:0]  sum;
   logic                done;
   logic                mistake;

   modport master (
      output in_valid, x, target, sum,
      input  in_ready, done, mistake
   );

   modport slave (
      input  in_valid, x, target, sum,
      output in_ready, done, mistake
   );
endinterface

// File: rtl/perceptron_update.sv
// Perceptron learning-rule engine: owns the weight bank and updates one weight per cycle.
// Define PERCEPTRON_UPDATE_SAT_EN to saturate weight adds instead of wrapping.
module perceptron_update #(
   parameter int                 N      = 8,
   parameter logic signed [31:0] RATE   = 32'sd1,
   parameter logic signed [31:0] THRESH = 32'sd0,
   localparam int                IDXW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst,
   perceptron_update_if.slave  bus,
   input  logic                wr_en,
   input  logic [IDXW-1:0]     wr_idx,
   input  logic signed [31:0]  wr_data,
   output logic [32*N-1:0]     w,
   output logic [15:0]         err_cnt
);

   typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

   state_t              state;
   logic [N-1:0]        x_q;
   logic                target_q;
   logic signed [31:0]  sum_q;
   logic                err_neg;
   logic [IDXW-1:0]     idx;
   logic signed [31:0]  w_q [N];
   logic signed [31:0]  step;
   logic                y;

   function automatic logic signed [31:0] add_w(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
`ifdef PERCEPTRON_UPDATE_SAT_EN
      logic signed [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31])
         return s[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
      return s[31:0];
`else
      return a + b;
`endif
   endfunction

   always_comb begin
      step = err_neg ? -RATE : RATE;
      y    = (sum_q >= THRESH);
   end

   for (genvar g = 0; g < N; g++) begin : g_wout
      assign w[32*g +: 32] = w_q[g];
   end

   // All handshake outputs are registered so they settle cleanly on state entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         x_q          <= '0;
         target_q     <= 1'b0;
         sum_q        <= '0;
         err_neg      <= 1'b0;
         idx          <= '0;
         bus.in_ready <= 1'b1;
         bus.done     <= 1'b0;
         bus.mistake  <= 1'b0;
         err_cnt      <= '0;
         for (int j = 0; j < N; j++) w_q[j] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en && (32'(wr_idx) < N))
                  w_q[wr_idx] <= wr_data;
               if (bus.in_valid && bus.in_ready) begin
                  x_q          <= bus.x;
                  target_q     <= bus.target;
                  sum_q        <= bus.sum;
                  bus.in_ready <= 1'b0;
                  state        <= EVAL;
               end
            end
            EVAL: begin
               if (target_q == y) begin
                  bus.done    <= 1'b1;
                  bus.mistake <= 1'b0;
                  state       <= DONE;
               end else begin
                  err_neg <= y;
                  idx     <= '0;
                  state   <= UPDATE;
               end
            end
            UPDATE: begin
               if (x_q[idx])
                  w_q[idx] <= add_w(w_q[idx], step);
               if (idx == IDXW'(N - 1)) begin
                  bus.done    <= 1'b1;
                  bus.mistake <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.mistake && (err_cnt != 16'hFFFF))
                  err_cnt <= err_cnt + 16'd1;
               bus.done     <= 1'b0;
               bus.mistake  <= 1'b0;
               bus.in_ready <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b1;
               bus.done     <= 1'b0;
               bus.mistake  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_update.sv
// Directed bench for perceptron_update (N=8, RATE=1, THRESH=0) with hand-computed weights.
module tb_perceptron_update;

   logic               clk = 1'b0;
   logic               rst;
   logic               wr_en;
   logic [2:0]         wr_idx;
   logic signed [31:0] wr_data;
   logic [255:0]       w;
   logic [15:0]        err_cnt;

   int errors = 0;
   int checks = 0;
   logic [31:0] expW [8];
   int   lat;
   logic mis;
   logic sawDone;

   always #5 clk = ~clk;

   perceptron_update_if #(.N(8)) bus ();

   perceptron_update #(.N(8), .RATE(32'sd1), .THRESH(32'sd0)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .w       (w),
      .err_cnt (err_cnt)
   );

   function automatic logic [255:0] packW();
      logic [255:0] p;
      for (int i = 0; i < 8; i++) p[32*i +: 32] = expW[i];
      return p;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one sample (optionally with a host write) and returns just after the accept edge.
   task automatic applyStimulus(input logic [7:0] xv, input logic tv, input logic [31:0] sv,
                                input logic we, input logic [2:0] wi, input logic [31:0] wd);
      @(negedge clk);
      bus.x        = xv;
      bus.target   = tv;
      bus.sum      = sv;
      bus.in_valid = 1'b1;
      wr_en        = we;
      wr_idx       = wi;
      wr_data      = wd;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wr_en        = 1'b0;
   endtask

   task automatic hostWrite(input logic [2:0] wi, input logic [31:0] wd);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_idx  = wi;
      wr_data = wd;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic waitDone(input int startLat, output int l, output logic m);
      bit found = 0;
      l = startLat;
      m = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         l++;
         if (bus.done === 1'b1) begin
            m = bus.mistake;
            found = 1;
            break;
         end
      end
      if (!found) l = -1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.x        = '0;
      bus.target   = 1'b0;
      bus.sum      = '0;
      wr_en        = 1'b0;
      wr_idx       = '0;
      wr_data      = '0;
      for (int i = 0; i < 8; i++) expW[i] = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_in_ready", 256'(bus.in_ready), 256'(1));
      checkOutput("reset_w", w, packW());
      checkOutput("reset_done", 256'(bus.done), 256'(0));
      checkOutput("reset_mistake", 256'(bus.mistake), 256'(0));
      checkOutput("reset_err_cnt", 256'(err_cnt), 256'(0));
      rst = 1'b1;

      $display("[TB] host write w[3]=5");
      hostWrite(3'd3, 32'd5);
      expW[3] = 32'd5;
      checkOutput("host_write_w3", w, packW());

      $display("[TB] mistake sample x=05 target=1 sum=-3");
      applyStimulus(8'h05, 1'b1, -32'sd3, 1'b0, 3'd0, 32'd0);
      waitDone(0, lat, mis);
      expW[0] = 32'd1;
      expW[2] = 32'd1;
      checkOutput("mistake_latency", 256'(lat), 256'(10));
      checkOutput("mistake_flag", 256'(mis), 256'(1));
      checkOutput("mistake_weights", w, packW());
      @(negedge clk);
      checkOutput("done_one_cycle", 256'(bus.done), 256'(0));
      checkOutput("in_ready_return", 256'(bus.in_ready), 256'(1));
      checkOutput("err_cnt_1", 256'(err_cnt), 256'(1));

      $display("[TB] correct sample x=FF target=1 sum=0");
      applyStimulus(8'hFF, 1'b1, 32'sd0, 1'b0, 3'd0, 32'd0);
      waitDone(0, lat, mis);
      checkOutput("correct_latency", 256'(lat), 256'(2));
      checkOutput("correct_flag", 256'(mis), 256'(0));
      checkOutput("correct_weights", w, packW());
      @(negedge clk);
      checkOutput("err_cnt_still_1", 256'(err_cnt), 256'(1));

      $display("[TB] overflow sample on w[1]");
      hostWrite(3'd1, 32'h7FFF_FFFF);
      applyStimulus(8'h02, 1'b1, -32'sd1, 1'b0, 3'd0, 32'd0);
      waitDone(0, lat, mis);
`ifdef PERCEPTRON_UPDATE_SAT_EN
      expW[1] = 32'h7FFF_FFFF;
`else
      expW[1] = 32'h8000_0000;
`endif
      checkOutput("overflow_latency", 256'(lat), 256'(10));
      checkOutput("overflow_weights", w, packW());
      @(negedge clk);
      checkOutput("err_cnt_2", 256'(err_cnt), 256'(2));

      $display("[TB] write with accept, plus ignored write during EVAL");
      applyStimulus(8'h01, 1'b0, 32'sd5, 1'b1, 3'd0, 32'd10);
      wr_en   = 1'b1;
      wr_idx  = 3'd6;
      wr_data = 32'd123;
      @(negedge clk);
      @(negedge clk);
      wr_en   = 1'b0;
      waitDone(2, lat, mis);
      expW[0] = 32'd9;
      checkOutput("combo_latency", 256'(lat), 256'(10));
      checkOutput("combo_flag", 256'(mis), 256'(1));
      checkOutput("combo_weights", w, packW());
      @(negedge clk);
      checkOutput("err_cnt_3", 256'(err_cnt), 256'(3));

      $display("[TB] reset during UPDATE");
      applyStimulus(8'hFF, 1'b0, 32'sd100, 1'b0, 3'd0, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("partial_w0", 256'(w[31:0]), 256'(32'd8));
      checkOutput("partial_w3", 256'(w[127:96]), 256'(32'd5));
      rst = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) expW[i] = '0;
      checkOutput("midreset_w", w, packW());
      checkOutput("midreset_in_ready", 256'(bus.in_ready), 256'(1));
      checkOutput("midreset_err_cnt", 256'(err_cnt), 256'(0));
      @(negedge clk);
      rst = 1'b1;
      sawDone = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) sawDone = 1'b1;
      end
      checkOutput("no_done_after_reset", 256'(sawDone), 256'(0));
      checkOutput("idle_after_reset", 256'(bus.in_ready), 256'(1));
      checkOutput("w_after_reset", w, packW());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
